chacha20_keystream_xor: RTL and testbench

Downstream consumer of the 64-byte keystream buffer from the concat/serialiser stage. It captures one full keystream block and XORs it byte-by-byte with a valid/ready plaintext stream to produce ciphertext. It tells the upstream buffer when a block has been taken and maintains the 32-bit ChaCha20 block counter fed back to the block-function core. Ciphertext output goes to the Poly1305 MAC path and the external output.

---
 rtl/chacha20_keystream_xor.sv | 197 +++++++++++++++++++
 tb/tb_chacha20_keystream_xor.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_keystream_xor.sv
// chacha20_keystream_xor
// Captures one 64-byte ChaCha20 keystream block from the upstream buffer and
// XORs it byte-by-byte with a valid/ready plaintext stream. Keeps the 32-bit
// block counter that feeds state word 12 of the block-function core.
//
// Optional feature macro: KS_XOR_MSG_LEN_EN
//   Defined   -> adds output msg_len[63:0], the running ciphertext byte count
//                of the current message (for the Poly1305 length block).
//   Undefined -> no msg_len port and no counter.
module chacha20_keystream_xor #(
    parameter int DATA_SIZE = 8,
    parameter int NO_REG    = 64,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ks_full,
    input  logic [DATA_SIZE-1:0] ks_bytes [NO_REG],
    output logic                 ks_consume,
    input  logic                 pt_valid,
    input  logic [DATA_SIZE-1:0] pt_data,
    input  logic                 pt_last,
    output logic                 pt_ready,
    output logic                 ct_valid,
    output logic [DATA_SIZE-1:0] ct_data,
    output logic                 ct_last,
    input  logic                 ct_ready,
    input  logic                 ctr_load,
    input  logic [CNT_W-1:0]     ctr_init,
    output logic [CNT_W-1:0]     block_ctr
`ifdef KS_XOR_MSG_LEN_EN
    ,
    output logic [63:0]          msg_len
`endif
);

    localparam int IDX_W = (NO_REG > 1) ? $clog2(NO_REG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NO_REG - 1);

    typedef enum logic [0:0] {
        ST_WAIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_SIZE-1:0] ks_buf_q [NO_REG];
    logic [DATA_SIZE-1:0] ks_buf_d [NO_REG];
    logic                 ct_valid_q, ct_valid_d;
    logic [DATA_SIZE-1:0] ct_data_q, ct_data_d;
    logic                 ct_last_q, ct_last_d;
    logic [CNT_W-1:0]     block_ctr_q, block_ctr_d;

    logic                 capture_s;
    logic                 pt_ready_s;
    logic                 xfer_s;
    logic                 eob_s;

    // Handshake qualifiers; reset masks everything so nothing leaks out while rst is high.
    always_comb begin
        capture_s  = (state_q == ST_WAIT) && ks_full && !rst;
        pt_ready_s = (state_q == ST_ACTIVE) && (!ct_valid_q || ct_ready) && !rst;
        xfer_s     = pt_valid && pt_ready_s;
        eob_s      = xfer_s && ((idx_q == IDX_LAST) || pt_last);
    end

    // Next-state logic: capture a block in WAIT, return to WAIT at end of block or message.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                if (capture_s) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACTIVE: begin
                if (eob_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Keystream buffer and byte index: loaded only on capture, so an active block is never overwritten.
    always_comb begin
        ks_buf_d = ks_buf_q;
        idx_d    = idx_q;
        if (capture_s) begin
            ks_buf_d = ks_bytes;
            idx_d    = '0;
        end else if (xfer_s) begin
            if (eob_s) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Ciphertext output register: load on transfer, hold under backpressure, drop valid once taken.
    always_comb begin
        ct_valid_d = ct_valid_q;
        ct_data_d  = ct_data_q;
        ct_last_d  = ct_last_q;
        if (xfer_s) begin
            ct_valid_d = 1'b1;
            ct_data_d  = pt_data ^ ks_buf_q[idx_q];
            ct_last_d  = pt_last;
        end else if (ct_valid_q && ct_ready) begin
            ct_valid_d = 1'b0;
        end else begin
            ct_valid_d = ct_valid_q;
        end
    end

    // Block counter: an explicit load wins over the end-of-block increment (which wraps naturally).
    always_comb begin
        block_ctr_d = block_ctr_q;
        if (ctr_load) begin
            block_ctr_d = ctr_init;
        end else if (eob_s) begin
            block_ctr_d = block_ctr_q + CNT_W'(1);
        end else begin
            block_ctr_d = block_ctr_q;
        end
    end

    // State, buffer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            idx_q       <= '0;
            ct_valid_q  <= 1'b0;
            ct_data_q   <= '0;
            ct_last_q   <= 1'b0;
            block_ctr_q <= '0;
            for (int i = 0; i < NO_REG; i++) begin
                ks_buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ct_valid_q  <= ct_valid_d;
            ct_data_q   <= ct_data_d;
            ct_last_q   <= ct_last_d;
            block_ctr_q <= block_ctr_d;
            ks_buf_q    <= ks_buf_d;
        end
    end

`ifdef KS_XOR_MSG_LEN_EN
    logic [63:0] msg_len_q, msg_len_d;

    // Message length: restart once the final ciphertext byte is taken, count every transfer.
    always_comb begin
        msg_len_d = msg_len_q;
        if (ct_valid_q && ct_ready && ct_last_q) begin
            msg_len_d = 64'd0;
        end else begin
            msg_len_d = msg_len_q;
        end
        if (xfer_s) begin
            msg_len_d = msg_len_d + 64'd1;
        end else begin
            msg_len_d = msg_len_d;
        end
    end

    // Message length register.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_len_q <= 64'd0;
        end else begin
            msg_len_q <= msg_len_d;
        end
    end

    assign msg_len = msg_len_q;
`endif

    assign ks_consume = capture_s;
    assign pt_ready   = pt_ready_s;
    assign ct_valid   = ct_valid_q;
    assign ct_data    = ct_data_q;
    assign ct_last    = ct_last_q;
    assign block_ctr  = block_ctr_q;

endmodule

// File: tb/tb_chacha20_keystream_xor.sv
// Self-checking bench for chacha20_keystream_xor. A stream-level reference
// model assigns each 64-byte chunk of every message to the next keystream
// block presented upstream, and predicts ciphertext and block counter.
module tb_chacha20_keystream_xor;

    localparam int DW   = 8;
    localparam int NR   = 64;
    localparam int CW   = 32;
    localparam int NBLK = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ks_full;
    logic [DW-1:0] ks_bytes [NR];
    logic          ks_consume;
    logic          pt_valid;
    logic [DW-1:0] pt_data;
    logic          pt_last;
    logic          pt_ready;
    logic          ct_valid;
    logic [DW-1:0] ct_data;
    logic          ct_last;
    logic          ct_ready;
    logic          ctr_load;
    logic [CW-1:0] ctr_init;
    logic [CW-1:0] block_ctr;

    chacha20_keystream_xor #(.DATA_SIZE(DW), .NO_REG(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ks_full(ks_full), .ks_bytes(ks_bytes),
        .ks_consume(ks_consume), .pt_valid(pt_valid), .pt_data(pt_data),
        .pt_last(pt_last), .pt_ready(pt_ready), .ct_valid(ct_valid),
        .ct_data(ct_data), .ct_last(ct_last), .ct_ready(ct_ready),
        .ctr_load(ctr_load), .ctr_init(ctr_init), .block_ctr(block_ctr)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            n_consume = 0;
    int            ks_ptr = 0;
    int            rdy_pct = 100;
    bit            ks_rand = 1'b0;
    bit            pt_fire = 1'b0;
    logic [7:0]    ks_blk [NBLK][NR];
    logic [7:0]    got_d [$];
    logic          got_l [$];
    logic [7:0]    exp_d [$];
    logic          exp_l [$];
    int            fire_cyc [$];
    // reference model state
    int            m_blk = 0;
    int            m_pos = 0;
    int            m_cur = 0;
    logic [31:0]   m_ctr = 32'd0;

    task automatic present_ks();
        for (int i = 0; i < NR; i++) ks_bytes[i] = ks_blk[ks_ptr % NBLK][i];
    endtask

    task automatic step();
        @(negedge clk);
        pt_fire = pt_valid && pt_ready;
        if (pt_fire) fire_cyc.push_back(cyc);
        if (ct_valid && ct_ready) begin
            got_d.push_back(ct_data);
            got_l.push_back(ct_last);
        end
        if (ks_consume === 1'b1) begin
            n_consume++;
            ks_ptr++;
        end
        @(posedge clk);
        #1;
        cyc++;
        ct_ready = ($urandom_range(99) < rdy_pct);
        if (ks_rand) ks_full = ($urandom_range(1) == 1);
        present_ks();
    endtask

    task automatic clear_q();
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete(); fire_cyc.delete();
    endtask

    // Present one plaintext byte until it is accepted; the model predicts its ciphertext.
    task automatic send_byte(input logic [7:0] d, input logic last, input logic ld, input logic [31:0] ld_val);
        int guard;
        if (m_pos == 0) begin
            m_cur = m_blk;
            m_blk++;
        end
        exp_d.push_back(d ^ ks_blk[m_cur % NBLK][m_pos]);
        exp_l.push_back(last);
        if (last || m_pos == NR - 1) begin
            m_pos = 0;
            m_ctr = m_ctr + 32'd1;
        end else begin
            m_pos++;
        end
        pt_valid = 1'b1; pt_data = d; pt_last = last; ctr_load = ld; ctr_init = ld_val;
        guard = 0;
        pt_fire = 1'b0;
        while (!pt_fire && guard < 400) begin
            step();
            guard++;
        end
        if (!pt_fire) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: byte not accepted after %0d cycles, required acceptance", guard);
        end
        pt_valid = 1'b0; pt_last = 1'b0; ctr_load = 1'b0;
    endtask

    task automatic send_msg(input int len, input bit with_last, input int idle_pct);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(99) < idle_pct) step();
            send_byte(8'($urandom), with_last && (i == len - 1), 1'b0, 32'd0);
        end
    endtask

    task automatic drain(input int n);
        rdy_pct = 100; ct_ready = 1'b1;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; ks_full = 1'b1; pt_valid = 1'b1; ct_ready = 1'b1; pt_data = 8'hA5;
        step(); step();
        vectors++;
        if ({ks_consume, pt_ready, ct_valid, ct_data, ct_last} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: consume/ready/valid/data/last=%b, required all 0",
                     {ks_consume, pt_ready, ct_valid, ct_data, ct_last});
        end
        vectors++;
        if (block_ctr !== 32'd0) begin
            miscompares++; $display("FAIL reset_ctr: got %h, required 0", block_ctr);
        end
        rst = 1'b0; ks_full = 1'b0; pt_valid = 1'b0;
        n_consume = 0;
        step();
        vectors++;
        if (pt_ready !== 1'b0 || n_consume != 0) begin
            miscompares++; $display("FAIL reset_idle: pt_ready=%b consumes=%0d, required 0/0", pt_ready, n_consume);
        end
        m_blk = ks_ptr; m_pos = 0; m_ctr = 32'd0;
        clear_q();
    endtask

    task automatic test_single_block();
        int g;
        ks_rand = 1'b0; ks_full = 1'b0; rdy_pct = 100; ct_ready = 1'b1;
        for (int i = 0; i < NR; i++) ks_blk[ks_ptr % NBLK][i] = i[7:0];
        present_ks();
        ctr_load = 1'b1; ctr_init = 32'd1; step(); ctr_load = 1'b0; m_ctr = 32'd1;
        clear_q(); n_consume = 0;
        ks_full = 1'b1;
        g = 0;
        while (n_consume == 0 && g < 20) begin step(); g++; end
        ks_full = 1'b0;
        for (int i = 0; i < NR; i++) send_byte(8'hFF, 1'b0, 1'b0, 32'd0);
        drain(4);
        vectors++;
        if (got_d.size() != NR) begin
            miscompares++; $display("FAIL single_count: got %0d bytes, required %0d", got_d.size(), NR);
        end
        for (int i = 0; i < got_d.size() && i < NR; i++) begin
            vectors++;
            if (got_d[i] !== (8'hFF ^ i[7:0]) || got_l[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL single_byte[%0d]: got %h/%b, required %h/0", i, got_d[i], got_l[i], 8'hFF ^ i[7:0]);
            end
        end
        vectors++;
        if (n_consume != 1) begin
            miscompares++; $display("FAIL single_consume: got %0d pulses, required 1", n_consume);
        end
        vectors++;
        if (block_ctr !== 32'd2 || pt_ready !== 1'b0) begin
            miscompares++; $display("FAIL single_end: ctr=%h pt_ready=%b, required 2/0", block_ctr, pt_ready);
        end
    endtask

    task automatic test_short_msg();
        int first;
        clear_q();
        ks_full = 1'b1; rdy_pct = 100;
        first = m_blk;
        for (int i = 0; i < 5; i++) send_byte(8'h00, (i == 4), 1'b0, 32'd0);
        drain(3);
        vectors++;
        if (got_d.size() != 5) begin
            miscompares++; $display("FAIL short_count: got %0d, required 5", got_d.size());
        end
        for (int i = 0; i < got_d.size() && i < 5; i++) begin
            vectors++;
            if (got_d[i] !== ks_blk[first % NBLK][i] || got_l[i] !== (i == 4)) begin
                miscompares++;
                $display("FAIL short_byte[%0d]: got %h/%b, required %h/%b", i, got_d[i], got_l[i],
                         ks_blk[first % NBLK][i], (i == 4));
            end
        end
        vectors++;
        if (block_ctr !== 32'd3) begin
            miscompares++; $display("FAIL short_ctr: got %h, required 3", block_ctr);
        end
        clear_q();
        send_msg(3, 1'b1, 0);
        drain(3);
        for (int i = 0; i < exp_d.size(); i++) begin
            vectors++;
            if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL short_fresh[%0d]: got %h, required %h", i,
                                        (i < got_d.size()) ? got_d[i] : 8'hxx, exp_d[i]);
            end
        end
        vectors++;
        if (block_ctr !== 32'd4) begin
            miscompares++; $display("FAIL short_ctr2: got %h, required 4", block_ctr);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        clear_q();
        ks_full = 1'b1; rdy_pct = 100;
        send_msg(30, 1'b0, 0);
        ct_ready = 1'b0; pt_valid = 1'b0;
        held = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (ct_valid !== 1'b1 || pt_ready !== 1'b0 || (k > 0 && ct_data !== held)) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b data=%h, required 1/0/%h", k, ct_valid, pt_ready, ct_data, held);
            end
            if (k == 0) held = ct_data;
            @(posedge clk); #1; cyc++;
        end
        ct_ready = 1'b1;
        send_msg(34, 1'b0, 0);
        drain(3);
        vectors++;
        if (got_d.size() != exp_d.size()) begin
            miscompares++; $display("FAIL bp_count: got %0d, required %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL bp_byte[%0d]: got %h, required %h", i, got_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ctr0;
        bit          gaps_ok;
        ks_full = 1'b1; rdy_pct = 100; pt_valid = 1'b0;
        step(); step();
        clear_q(); n_consume = 0;
        ctr0 = m_ctr;
        send_msg(2 * NR, 1'b0, 0);
        drain(3);
        vectors++;
        if (fire_cyc.size() != 2 * NR || fire_cyc[NR] - fire_cyc[NR - 1] != 2) begin
            miscompares++; $display("FAIL b2b_gap: transfers=%0d gap=%0d, required %0d/2", fire_cyc.size(),
                                    (fire_cyc.size() > NR) ? fire_cyc[NR] - fire_cyc[NR - 1] : -1, 2 * NR);
        end
        gaps_ok = 1'b1;
        for (int i = 1; i < fire_cyc.size(); i++)
            if (i != NR && fire_cyc[i] - fire_cyc[i - 1] != 1) gaps_ok = 1'b0;
        vectors++;
        if (!gaps_ok) begin
            miscompares++; $display("FAIL b2b_rate: got stalls inside a block, required 1 byte/cycle");
        end
        vectors++;
        if (n_consume != 2) begin
            miscompares++; $display("FAIL b2b_consume: got %0d, required 2", n_consume);
        end
        vectors++;
        if (block_ctr !== ctr0 + 32'd2) begin
            miscompares++; $display("FAIL b2b_ctr: got %h, required %h", block_ctr, ctr0 + 32'd2);
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i]) begin
                miscompares++; $display("FAIL b2b_byte[%0d]: got %h, required %h", i, got_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_ctr_wrap();
        clear_q();
        ks_full = 1'b1; rdy_pct = 100;
        ctr_load = 1'b1; ctr_init = 32'hFFFF_FFFF; step(); ctr_load = 1'b0;
        m_ctr = 32'hFFFF_FFFF;
        send_msg(NR, 1'b0, 0);
        drain(3);
        vectors++;
        if (block_ctr !== 32'd0) begin
            miscompares++; $display("FAIL wrap_ctr: got %h, required 0", block_ctr);
        end
        for (int i = 0; i < NR - 1; i++) send_byte(8'($urandom), 1'b0, 1'b0, 32'd0);
        send_byte(8'($urandom), 1'b0, 1'b1, 32'd5);
        m_ctr = 32'd5;
        drain(3);
        vectors++;
        if (block_ctr !== 32'd5) begin
            miscompares++; $display("FAIL load_priority: got %h, required 5", block_ctr);
        end
        vectors++;
        if (got_d.size() != exp_d.size()) begin
            miscompares++; $display("FAIL wrap_count: got %0d, required %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i]) begin
                miscompares++; $display("FAIL wrap_byte[%0d]: got %h, required %h", i, got_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_q();
        ks_rand = 1'b1; rdy_pct = 70;
        for (int m = 0; m < 6; m++) send_msg($urandom_range(150, 1), 1'b1, 20);
        ks_rand = 1'b0; ks_full = 1'b1;
        drain(5);
        vectors++;
        if (got_d.size() != exp_d.size()) begin
            miscompares++; $display("FAIL rand_count: got %0d, required %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL rand_byte[%0d]: got %h/%b, required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (block_ctr !== m_ctr) begin
            miscompares++; $display("FAIL rand_ctr: got %h, required %h", block_ctr, m_ctr);
        end
    endtask

    task automatic test_mid_reset();
        ks_full = 1'b1; rdy_pct = 100;
        send_msg(10, 1'b0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (ct_valid !== 1'b0 || pt_ready !== 1'b0 || block_ctr !== 32'd0 || ct_data !== 8'd0) begin
            miscompares++;
            $display("FAIL midrst_clear: valid=%b ready=%b ctr=%h data=%h, required 0/0/0/0", ct_valid, pt_ready, block_ctr, ct_data);
        end
        m_blk = ks_ptr; m_pos = 0; m_ctr = 32'd0;
        clear_q();
        send_msg(20, 1'b1, 0);
        drain(3);
        for (int i = 0; i < exp_d.size(); i++) begin
            vectors++;
            if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL midrst_byte[%0d]: got %h, required %h", i,
                                        (i < got_d.size()) ? got_d[i] : 8'hxx, exp_d[i]);
            end
        end
        vectors++;
        if (block_ctr !== 32'd1) begin
            miscompares++; $display("FAIL midrst_ctr: got %h, required 1", block_ctr);
        end
    endtask

    initial begin
        rst = 1'b1; ks_full = 1'b0; pt_valid = 1'b0; pt_data = 8'd0; pt_last = 1'b0;
        ct_ready = 1'b1; ctr_load = 1'b0; ctr_init = 32'd0;
        for (int b = 0; b < NBLK; b++)
            for (int i = 0; i < NR; i++) ks_blk[b][i] = 8'($urandom);
        present_ks();
        test_reset();
        test_single_block();
        test_short_msg();
        test_backpressure();
        test_back_to_back();
        test_ctr_wrap();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
